// File: rtl/priv_hpm_counter_bank.sv
// priv_hpm_counter_bank
//   Bank of RISC-V hardware performance monitor counters that sits beside the
//   machine-mode CSR file and decodes its own addresses from the shared CSR bus:
//     0x320        mcountinhibit (bit 3+i stops counter i)
//     0x323+i      mhpmevent(3+i)   [7:0] event selector, [31] sticky overflow
//     0xB03+i      mhpmcounter(3+i)  low 32 bits
//     0xB83+i      mhpmcounter(3+i)h high bits (COUNTER_WIDTH-32 of them)
//
//   Ports
//     clk_i               clock, rising edge
//     rst_i               asynchronous reset, active-high
//     csr_addr_i          CSR address from the pipeline
//     csr_swap_i          CSRRW-type op
//     csr_set_i           CSRRS-type op
//     csr_clr_i           CSRRC-type op
//     csr_valid_write_i   write permitted this cycle
//     csr_wdata_i         write operand
//     csr_rdata_o         combinational read data for csr_addr_i
//     csr_hit_o           csr_addr_i decodes to a register in this bank
//     events_i            per-cycle event pulses
//     ovf_irq_o           registered OR of all overflow flags
//
//   CSR bus qualification: there is no valid/ready handshake. A write happens
//   at the next clock edge when the address hits this bank, csr_valid_write_i
//   is high and exactly one of swap/set/clr is high; reads are always live.
module priv_hpm_counter_bank #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [11:0]           csr_addr_i,
    input  logic                  csr_swap_i,
    input  logic                  csr_set_i,
    input  logic                  csr_clr_i,
    input  logic                  csr_valid_write_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    input  logic [NUM_EVENTS-1:0] events_i,
    output logic                  ovf_irq_o
);

    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic [7:0]               sel_q [NUM_COUNTERS];
    logic [7:0]               sel_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  of_q, of_d;
    logic [NUM_COUNTERS-1:0]  inh_q, inh_d;
    logic                     irq_q, irq_d;

    logic [63:0]              cnt_ext [NUM_COUNTERS];
    logic                     acc_inh;
    logic [NUM_COUNTERS-1:0]  acc_evt, acc_lo, acc_hi;
    logic [NUM_COUNTERS-1:0]  inc, wrap;
    logic                     wr_en;
    logic [31:0]              wval;
    logic [7:0]               sel_legal;
    logic [255:0]             ev_ext;

    // Bit 0 is a constant zero so selector value 0 naturally counts nothing
    // and selector k lands on events_i[k-1].
    assign ev_ext = 256'({events_i, 1'b0});

    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_ext[i] = 64'(cnt_q[i]);
        end
    end

    // Address decode and read mux.
    always_comb begin
        csr_hit_o   = 1'b0;
        csr_rdata_o = '0;
        acc_inh     = 1'b0;
        acc_evt     = '0;
        acc_lo      = '0;
        acc_hi      = '0;
        if (csr_addr_i == 12'h320) begin
            acc_inh     = 1'b1;
            csr_hit_o   = 1'b1;
            csr_rdata_o = 32'(inh_q) << 3;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (csr_addr_i == 12'(32'h323 + i)) begin
                acc_evt[i]  = 1'b1;
                csr_hit_o   = 1'b1;
                csr_rdata_o = {of_q[i], 23'd0, sel_q[i]};
            end
            if (csr_addr_i == 12'(32'hB03 + i)) begin
                acc_lo[i]   = 1'b1;
                csr_hit_o   = 1'b1;
                csr_rdata_o = cnt_ext[i][31:0];
            end
            if (csr_addr_i == 12'(32'hB83 + i)) begin
                acc_hi[i]   = 1'b1;
                csr_hit_o   = 1'b1;
                csr_rdata_o = cnt_ext[i][63:32];
            end
        end
    end

    // Address strobes already imply a hit, so the hit term is folded in there.
    assign wr_en = csr_valid_write_i & (csr_swap_i | csr_set_i | csr_clr_i);
    assign wval  = csr_swap_i ? csr_wdata_i :
                   csr_set_i  ? (csr_rdata_o | csr_wdata_i) :
                                (csr_rdata_o & ~csr_wdata_i);

    // WARL selector: anything outside 1..NUM_EVENTS is stored as 0.
    assign sel_legal = (wval[7:0] != 8'd0 && {1'b0, wval[7:0]} <= 9'(NUM_EVENTS))
                       ? wval[7:0] : 8'd0;

    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            inc[i]  = ev_ext[sel_q[i]] & ~inh_q[i];
            wrap[i] = inc[i] & (&cnt_q[i]) & ~(wr_en & (acc_lo[i] | acc_hi[i]));
        end
    end

    // Next state. A CSR write to either counter half suppresses that
    // cycle's increment; a CSR write of OF overrides a same-cycle wrap.
    always_comb begin
        inh_d = inh_q;
        of_d  = of_q;
        irq_d = |of_q;
        if (wr_en && acc_inh) begin
            inh_d = wval[3 +: NUM_COUNTERS];
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
            if (wr_en && acc_lo[i]) begin
                cnt_d[i] = {cnt_q[i][COUNTER_WIDTH-1:32], wval};
            end else if (wr_en && acc_hi[i]) begin
                cnt_d[i] = {wval[COUNTER_WIDTH-33:0], cnt_q[i][31:0]};
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
            end
            if (wr_en && acc_evt[i]) begin
                sel_d[i] = sel_legal;
                of_d[i]  = wval[31];
            end else if (wrap[i]) begin
                of_d[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            of_q  <= '0;
            inh_q <= '1;
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            of_q  <= of_d;
            inh_q <= inh_d;
            irq_q <= irq_d;
        end
    end

    assign ovf_irq_o = irq_q;

endmodule

// File: tb/tb_priv_hpm_counter_bank.sv
module tb_priv_hpm_counter_bank;
  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 8;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [11:0]   csr_addr;
  logic          csr_swap, csr_set, csr_clr, csr_valid_write;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic [NE-1:0] events;
  logic          ovf_irq;

  priv_hpm_counter_bank #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(CW),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .csr_addr_i       (csr_addr),
    .csr_swap_i       (csr_swap),
    .csr_set_i        (csr_set),
    .csr_clr_i        (csr_clr),
    .csr_valid_write_i(csr_valid_write),
    .csr_wdata_i      (csr_wdata),
    .csr_rdata_o      (csr_rdata),
    .csr_hit_o        (csr_hit),
    .events_i         (events),
    .ovf_irq_o        (ovf_irq)
  );

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];   // {hit, rdata, irq}
  logic [11:0] addr_q[$];
  logic mon_valid = 1'b0;

  // reference model: architectural state as plain values
  logic [63:0] m_cnt [NC];
  int          m_sel [NC];
  logic        m_of  [NC];
  logic        m_inh [NC];
  logic        m_irq;

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 64'd0;
      m_sel[i] = 0;
      m_of[i]  = 1'b0;
      m_inh[i] = 1'b1;
    end
    m_irq = 1'b0;
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic hit, output logic [31:0] r);
    hit = 1'b0;
    r   = 32'd0;
    if (int'(a) == 'h320) begin
      hit = 1'b1;
      for (int i = 0; i < NC; i++) r[3+i] = m_inh[i];
    end
    for (int i = 0; i < NC; i++) begin
      if (int'(a) == 'h323 + i) begin
        hit = 1'b1;
        r = {m_of[i], 23'd0, 8'(m_sel[i])};
      end
      if (int'(a) == 'hB03 + i) begin
        hit = 1'b1;
        r = m_cnt[i][31:0];
      end
      if (int'(a) == 'hB83 + i) begin
        hit = 1'b1;
        r = m_cnt[i][63:32];
      end
    end
  endfunction

  // driver: one clock cycle of bus activity; expectation pushed, model stepped
  task automatic cyc(input logic [11:0] a, input int op, input logic vw,
                     input logic [31:0] wd, input logic [NE-1:0] ev);
    logic hit;
    logic [31:0] r, val;
    logic wr, any_of, wrapped, cw;
    csr_addr = a;
    csr_swap = (op == 1);
    csr_set = (op == 2);
    csr_clr = (op == 3);
    csr_valid_write = vw;
    csr_wdata = wd;
    events = ev;
    m_read(a, hit, r);
    exp_q.push_back({hit, r, m_irq});
    addr_q.push_back(a);
    mon_valid = 1'b1;
    @(posedge clk);
    any_of = 1'b0;
    for (int i = 0; i < NC; i++) any_of = any_of | m_of[i];
    wr = hit && vw && (op != 0);
    val = (op == 1) ? wd : (op == 2) ? (r | wd) : (r & ~wd);
    for (int i = 0; i < NC; i++) begin
      wrapped = 1'b0;
      cw = wr && (int'(a) == 'hB03 + i || int'(a) == 'hB83 + i);
      if (!cw && m_sel[i] != 0 && ev[m_sel[i]-1] && !m_inh[i]) begin
        if (m_cnt[i] == MASK) begin
          m_cnt[i] = 64'd0;
          wrapped = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 64'd1;
        end
      end
      if (wr && int'(a) == 'hB03 + i) m_cnt[i] = {m_cnt[i][63:32], val} & MASK;
      if (wr && int'(a) == 'hB83 + i) m_cnt[i] = {val, m_cnt[i][31:0]} & MASK;
      if (wr && int'(a) == 'h323 + i) begin
        m_sel[i] = (val[7:0] >= 1 && int'(val[7:0]) <= NE) ? int'(val[7:0]) : 0;
        m_of[i] = val[31];
      end else if (wrapped) begin
        m_of[i] = 1'b1;
      end
    end
    if (wr && int'(a) == 'h320) begin
      for (int i = 0; i < NC; i++) m_inh[i] = val[3+i];
    end
    m_irq = any_of;
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    cyc(a, 0, 1'b0, 32'd0, '0);
  endtask

  // reset asserted between edges while a write is being presented
  task automatic async_reset_mid();
    logic hit;
    logic [31:0] r;
    csr_addr = 12'h320;
    csr_swap = 1'b1;
    csr_set = 1'b0;
    csr_clr = 1'b0;
    csr_valid_write = 1'b1;
    csr_wdata = 32'd0;
    events = '1;
    #2;
    rst = 1'b1;
    m_reset();
    m_read(12'h320, hit, r);
    exp_q.push_back({hit, r, m_irq});
    addr_q.push_back(12'h320);
    mon_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_valid) begin
      logic [33:0] e;
      logic [11:0] a;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow got hit=%0d rdata=%h irq=%0d required an expectation",
                 csr_hit, csr_rdata, ovf_irq);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if ({csr_hit, csr_rdata, ovf_irq} !== e) begin
          failures++;
          $display("FAIL csr_read addr=%h got hit=%0d rdata=%h irq=%0d required hit=%0d rdata=%h irq=%0d",
                   a, csr_hit, csr_rdata, ovf_irq, e[33], e[32:1], e[0]);
        end
      end
    end
  end

  logic [11:0] addr_tab [18];

  initial begin
    addr_tab = '{12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327,
                 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB07,
                 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB87, 12'h321, 12'h300};
    rst = 1'b1;
    csr_addr = 12'd0;
    csr_swap = 1'b0;
    csr_set = 1'b0;
    csr_clr = 1'b0;
    csr_valid_write = 1'b0;
    csr_wdata = 32'd0;
    events = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    rd(12'h320);
    rd(12'hB03);
    rd(12'h323);

    // count on selected event only
    cyc(12'h323, 1, 1'b1, 32'd2, '0);
    cyc(12'h320, 3, 1'b1, 32'h8, '0);
    repeat (5) cyc(12'hB03, 0, 1'b0, 32'd0, 8'b0000_0010);
    repeat (3) cyc(12'hB03, 0, 1'b0, 32'd0, 8'b0000_0001);
    rd(12'hB03);

    // wrap, sticky OF, irq, clear
    cyc(12'hB03, 1, 1'b1, 32'hFFFF_FFFF, '0);
    cyc(12'hB83, 1, 1'b1, 32'hFFFF_FFFF, '0);
    rd(12'hB83);
    cyc(12'hB03, 0, 1'b0, 32'd0, 8'b0000_0010);
    rd(12'h323);
    rd(12'hB83);
    cyc(12'h323, 3, 1'b1, 32'h8000_0000, '0);
    repeat (3) rd(12'h323);

    // write beats increment; set/clr touch only addressed bits
    cyc(12'hB03, 1, 1'b1, 32'h10, 8'b0000_0010);
    rd(12'hB03);
    cyc(12'hB03, 2, 1'b1, 32'h100, '0);
    cyc(12'hB03, 3, 1'b1, 32'h10, '0);
    rd(12'hB03);
    cyc(12'hB03, 2, 1'b0, 32'hF000, '0);  // write not permitted
    rd(12'hB03);

    // WARL selector, unimplemented index
    cyc(12'h323, 1, 1'b1, NE + 1, '0);
    cyc(12'h323, 0, 1'b0, 32'd0, '1);
    cyc(12'hB03, 0, 1'b0, 32'd0, '1);
    cyc(12'hB07, 1, 1'b1, 32'h1234, '1);
    cyc(12'h327, 1, 1'b1, 32'h1, '1);
    rd(12'hB87);

    // OF hook and wrap racing a write of OF
    cyc(12'h324, 1, 1'b1, 32'h8000_0001, '0);
    cyc(12'h320, 1, 1'b1, 32'h0, '0);
    cyc(12'hB04, 1, 1'b1, 32'hFFFF_FFFF, '0);
    cyc(12'hB84, 1, 1'b1, 32'hFF, '0);
    cyc(12'h324, 1, 1'b1, 32'h1, 8'b0000_0001);
    rd(12'h324);
    rd(12'hB84);

    // async reset mid-write
    async_reset_mid();
    rd(12'h320);
    rd(12'hB04);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] wd;
      case ($urandom_range(0, 3))
        0: wd = $urandom;
        1: wd = 32'hFFFF_FFFF;
        2: wd = 32'hFFFF_FFFE;
        default: wd = $urandom_range(0, 12);
      endcase
      cyc(addr_tab[$urandom_range(0, 17)], $urandom_range(0, 3),
          logic'($urandom_range(0, 3) != 0), wd, NE'($urandom));
    end

    mon_valid = 1'b0;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
